booth_multiplier_8bit: RTL and testbench
========================================

Name: booth_multiplier_8bit

Overview:
- Pipelined 8-bit × 8-bit signed (two's-complement) multiplier using radix-4 (modified) Booth recoding, producing a 16-bit product.
- Datapath arithmetic core of the AXI-Stream DSP accelerator, fed by the stream front-end.
- Accepts one operand pair every clock cycle with fixed latency.
- No handshake; stream flow control lives in the wrapper.

Parameters:
- WIDTH, 8, operand width in bits. Only 8 is required to be supported.
- LATENCY, 3, clock cycles from operand sample edge to product valid on P. Fixed structural value, not user-tunable.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  8  multiplicand, signed two's complement.
- B  input  8  multiplier, signed two's complement.
- P  output  16  registered product A*B, signed two's complement.

Behaviour:
- One clock; reset is asynchronous and active-high.
- On rst assertion, all pipeline registers and P clear to 0 immediately, without waiting for a clock edge.
- Reset mid-operation discards all in-flight products.
- After rst deasserts, P stays 0 until the first real product emerges.
- Stage 1 (edge n): register A and B.
- Stage 2 (edge n+1):
  - Radix-4 Booth-encode B. Form B[-1]=0, then take triplets {B[2i+1],B[2i],B[2i-1]} for i=0..3.
  - Each triplet selects a digit: 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
  - Generate 4 partial products, each sign-extended to 16 bits and shifted left by 2i.
  - Register all 4 partial products.
- Stage 3 (edge n+2): sum the 4 partial products modulo 2^16 and register the sum into P.
- Latency: inputs sampled at edge n appear on P after edge n+2. That is 3 sampling edges, including the input register.
- Throughput: 1 product per cycle. Inputs may change every cycle. P is a pure function of the pair sampled 3 cycles earlier.
- Width rules:
  - Negation of ±2A uses 10-bit intermediates, so -2*(-128) = +256 is exact.
  - Final result is exact for the full signed range: min -128*127 = -16256, max -128*-128 = 16384. No overflow or saturation.
- P holds steady between edges. Inputs are not held internally beyond the pipeline.

Decomposition:
- Shared package booth_pkg holds:
  - constants OP_W=8, PROD_W=16, NUM_PP=4.
  - enum booth_digit_t {ZERO, POS1, POS2, NEG1, NEG2}.
  - function returning the digit for a 3-bit triplet.
- One natural sub-module: booth_radix4_pp_gen.
  - Inputs: 8-bit A, 3-bit triplet.
  - Output: 16-bit sign-extended, unshifted partial product.
  - Instantiated 4× in stage 2.
- Adder tree (two-level) stays inline in the top module.

Test Plan:
- Reset: assert rst mid-stream with nonzero inputs -> P becomes 0x0000 asynchronously, before the next clk edge. After release, P stays 0 until new data has passed 3 edges.
- Basic and zero cases:
  - A=0,B=0 -> P=0x0000.
  - A=50,B=0 -> P=0x0000.
  - A=5,B=7 -> P=0x0023.
  - A=123,B=45 -> P=0x159F.
  - A=77,B=88 -> P=0x1A78.
  - Each value checked exactly 3 edges after the operands are applied.
- Signed cases:
  - A=0xFF,B=0xFF (-1*-1) -> P=0x0001.
  - A=10,B=0xFC (-4) -> P=0xFFD8.
  - A=0xF1,B=0xFE (-15*-2) -> P=0x001E.
  - A=0xFA,B=3 -> P=0xFFEE.
- Patterns and extremes:
  - A=0xAA,B=0x55 -> P=0xE372.
  - A=0x80,B=0x80 -> P=0x4000.
  - A=0x80,B=0x7F -> P=0xC080.
  - A=0x7F,B=0x7F -> P=0x3F01.
- Back-to-back throughput: new operand pair every cycle for 20 cycles -> P sequence matches the inputs delayed by exactly 3 cycles, with no bubbles.
- Random regression: 10,000 random pairs, compared against a signed reference model delayed 3 cycles -> zero mismatches.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants, digit encoding and triplet decoder for the radix-4 Booth multiplier.
package booth_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned NUM_PP = 4;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    function automatic booth_digit_t booth_digit(input logic [2:0] trip);
        booth_digit_t dig;
        case (trip)
            3'b001, 3'b010: dig = POS1;
            3'b011:         dig = POS2;
            3'b100:         dig = NEG2;
            3'b101, 3'b110: dig = NEG1;
            default:        dig = ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_radix4_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +-A or +-2A from a triplet of the multiplier,
// sign-extended to the product width and left unshifted.
module booth_radix4_pp_gen
    import booth_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [2:0]        trip,
    output logic [PROD_W-1:0] pp
);

    booth_digit_t    dig;
    logic [OP_W+1:0] a1;
    logic [OP_W+1:0] a2;
    logic [OP_W+1:0] val;

    // Two guard bits keep -2*(-128) = +256 representable before sign extension.
    always_comb begin
        dig = booth_digit(trip);
        a1  = {{2{a[OP_W-1]}}, a};
        a2  = {a1[OP_W:0], 1'b0};
        val = '0;
        case (dig)
            POS1:    val = a1;
            POS2:    val = a2;
            NEG1:    val = -a1;
            NEG2:    val = -a2;
            default: val = '0;
        endcase
        pp = {{(PROD_W - OP_W - 2){val[OP_W+1]}}, val};
    end

endmodule

// File: rtl/booth_multiplier_8bit.sv
// Three-stage signed 8x8 radix-4 Booth multiplier: operand register, partial-product
// register, then a two-level adder tree into the product register.
module booth_multiplier_8bit
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH   = OP_W,
    parameter int unsigned LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P
);

    if (WIDTH != OP_W || LATENCY != 3) begin : g_param_check
        $error("booth_multiplier_8bit supports only WIDTH=8, LATENCY=3");
    end

    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [OP_W:0]     b_ext;
    logic [PROD_W-1:0] pp_raw [NUM_PP];
    logic [PROD_W-1:0] pp_sh  [NUM_PP];
    logic [PROD_W-1:0] pp_q   [NUM_PP];
    logic [PROD_W-1:0] sum_lo;
    logic [PROD_W-1:0] sum_hi;
    logic [PROD_W-1:0] sum;

    // Implicit B[-1] = 0 below the LSB.
    assign b_ext = {b_q, 1'b0};

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        booth_radix4_pp_gen u_pp_gen (
            .a    (a_q),
            .trip (b_ext[2*i+2:2*i]),
            .pp   (pp_raw[i])
        );
        assign pp_sh[i] = pp_raw[i] << (2 * i);
    end

    always_comb begin
        sum_lo = pp_q[0] + pp_q[1];
        sum_hi = pp_q[2] + pp_q[3];
        sum    = sum_lo + sum_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_q[i] <= '0;
            end
            P   <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_q[i] <= pp_sh[i];
            end
            P   <= sum;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_8bit.sv
// Directed and random checks of the 3-cycle Booth multiplier against a delayed expected stream.
module tb_booth_multiplier_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;

    int checks = 0;
    int errors = 0;

    // Expected-value pipeline: s1 after the sampling edge, s2 one edge later, p_m on P.
    logic [15:0] s1_m;
    logic [15:0] s2_m;
    logic [15:0] p_m;

    logic [7:0]  da [13] = '{8'd0, 8'd50, 8'd5, 8'd123, 8'd77, 8'hFF, 8'd10, 8'hF1, 8'hFA,
                             8'hAA, 8'h80, 8'h80, 8'h7F};
    logic [7:0]  db [13] = '{8'd0, 8'd0, 8'd7, 8'd45, 8'd88, 8'hFF, 8'hFC, 8'hFE, 8'd3,
                             8'h55, 8'h80, 8'h7F, 8'h7F};
    logic [15:0] dp [13] = '{16'h0000, 16'h0000, 16'h0023, 16'h159F, 16'h1A78, 16'h0001,
                             16'hFFD8, 16'h001E, 16'hFFEE, 16'hE372, 16'h4000, 16'hC080,
                             16'h3F01};

    booth_multiplier_8bit dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (P)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    task automatic clear_model();
        s1_m = '0;
        s2_m = '0;
        p_m  = '0;
    endtask

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        p_m  = s2_m;
        s2_m = s1_m;
        s1_m = exp;
        check_eq(tag, P, p_m);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1'b0;
        A   = '0;
        B   = '0;
        clear_model();
        #1 rst = 1'b1;
        #1 check_eq("reset_init", P, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step("directed", da[i], db[i], dp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            step("flush", 8'd0, 8'd0, 16'h0000);
        end

        // Mid-stream reset with nonzero operands in flight and on the inputs.
        step("pre_rst", 8'd5, 8'd7, 16'h0023);
        step("pre_rst", 8'd123, 8'd45, 16'h159F);
        step("pre_rst", 8'd77, 8'd88, 16'h1A78);
        step("pre_rst", 8'hAA, 8'h55, 16'hE372);
        #2 rst = 1'b1;
        #1 check_eq("async_rst", P, 16'h0000);
        @(posedge clk);
        #1 check_eq("rst_hold", P, 16'h0000);
        rst = 1'b0;
        clear_model();
        step("post_rst", 8'd5, 8'd7, 16'h0023);
        step("post_rst", 8'hFA, 8'd3, 16'hFFEE);
        step("post_rst", 8'h80, 8'h80, 16'h4000);
        step("post_rst", 8'd0, 8'd0, 16'h0000);
        step("post_rst", 8'd0, 8'd0, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            ra = 8'(i * 37 + 11);
            rb = 8'(200 - i * 29);
            step("back_to_back", ra, rb, ref_mul(ra, rb));
        end

        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            step("random", ra, rb, ref_mul(ra, rb));
        end
        for (int i = 0; i < 3; i++) begin
            step("drain", 8'd0, 8'd0, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
